gth_tx_bringup_ctrl: RTL and testbench
======================================

# gth_tx_bringup_ctrl

Sequences bring-up of the three-lane GTH TMDS serializer, which carries the 10-bit r/g/b channels plus the TMDS clock. It holds the transceiver wizard in reset, then waits in order for power-good, TX reset completion and PLL lock. It enables the serializer output (`out_en`) only after the link has been stable for a settle period. Timeouts, bounded retries, loss-of-lock recovery and a sticky fault state make it the supervisory FSM that sits between system reset and the serializer.

## Interface
- `RESET_HOLD_CYCLES`, default 64: cycles `gtwiz_reset_all` is held high per reset attempt (≥1).
- `TIMEOUT_CYCLES`, default 65536: maximum cycles spent in any wait state (≥2).
- `SETTLE_CYCLES`, default 256: cycles all status must stay good before `out_en` (≥1).
- `MAX_RETRY`, default 3: timeouts tolerated before FAULT (0..15).
- `clk`, in, 1: free-running system clock; all logic is on this clock.
- `resetn`, in, 1: one clock; reset is asynchronous and active-low.
- `enable`, in, 1: bring-up request; low forces IDLE.
- `gtpowergood`, in, 3: per-lane GTH power good.
- `txpmaresetdone`, in, 3: per-lane TX PMA reset done.
- `txprgdivresetdone`, in, 3: per-lane TX programmable-divider reset done.
- `gtwiz_reset_tx_done`, in, 1: wizard TX reset done.
- `locked`, in, 1: TMDS clock MMCM lock.
- `gtwiz_reset_all`, out, 1: wizard reset_all request.
- `out_en`, out, 1: serializer output enable.
- `fault`, out, 1: bring-up failed; sticky until `enable` is low.
- `state`, out, 3: current FSM state encoding.
- `retry_cnt`, out, 4: timeouts consumed in the current bring-up.
- `link_drop_cnt`, out, 8: saturating count of RUN→RESET drops since `resetn`.

## Operation
- Moore FSM; all outputs decode from registered state or counters.
- Status terms:
  - `pg = &gtpowergood`.
  - `txok = gtwiz_reset_tx_done & &txpmaresetdone & &txprgdivresetdone`.
- Output decode:
  - `gtwiz_reset_all` = 1 in IDLE, WAIT_PG, RESET and FAULT.
  - `out_en` = 1 only in RUN.
  - `fault` = 1 only in FAULT.
- States and transitions:
  - IDLE (0): on `enable`, go to WAIT_PG.
  - WAIT_PG (1): on `pg`, go to RESET.
  - RESET (2): stay exactly `RESET_HOLD_CYCLES` cycles, then go to WAIT_TX.
  - WAIT_TX (3): on `txok`, go to WAIT_LOCK.
  - WAIT_LOCK (4): on `locked & txok`, go to SETTLE; on loss of `txok`, go to RESET.
  - SETTLE (5): stay `SETTLE_CYCLES` consecutive cycles with `pg & txok & locked`, then go to RUN. Any drop goes to RESET and consumes one retry using the timeout rule.
  - RUN (6): any drop of `pg`, `txok` or `locked` goes to RESET and increments `link_drop_cnt` (saturates at 255).
  - FAULT (7): leave only on `!enable`, to IDLE.
- Timer:
  - Cleared on every state entry.
  - Increments each cycle in WAIT_PG, RESET, WAIT_TX, WAIT_LOCK and SETTLE.
  - Width is `$clog2` of the maximum parameter, plus 1.
- Timeout: in WAIT_PG, WAIT_TX or WAIT_LOCK, a timer value of `TIMEOUT_CYCLES-1` with the exit condition false is a timeout.
  - If `retry_cnt == MAX_RETRY`, go to FAULT.
  - Otherwise increment `retry_cnt` and go to RESET.
- `retry_cnt` clears on entry to RUN and in IDLE.
- Priority:
  1. `!enable`: go to IDLE from any state.
  2. Exit condition.
  3. Timeout.
- When the exit condition and timeout fall on the same cycle, the exit is taken.

## Timing
- Reset values, held while `resetn` = 0:
  - `state` = IDLE.
  - `gtwiz_reset_all` = 1.
  - `out_en`, `fault` = 0.
  - `retry_cnt`, `link_drop_cnt` = 0.
  - timer = 0.
- Reset mid-operation:
  - `resetn` low asynchronously forces the reset values.
  - `out_en` falls within the same cycle, with no wait for a clock edge.
- Status-to-state latency: 1 cycle with the macro off, 3 cycles with it on.
- `out_en` rises exactly `SETTLE_CYCLES` cycles after SETTLE entry.
- `out_en` falls on the first edge after a detected drop or `!enable`.
- `gtwiz_reset_all` pulse width per attempt is exactly `RESET_HOLD_CYCLES` cycles of RESET. When coming from WAIT_PG, the pulse additionally includes the WAIT_PG/IDLE time.

## Configuration
- `GTH_BRINGUP_SYNC_EN` defined:
  - Each status input (`gtpowergood`, `txpmaresetdone`, `txprgdivresetdone`, `gtwiz_reset_tx_done`, `locked`) passes through a 2-flop synchronizer into `clk`.
  - Synchronizer flops reset to 0.
  - Adds 2 cycles of status latency.
- `GTH_BRINGUP_SYNC_EN` undefined: status inputs are used directly. They are required to be synchronous to `clk`.

## Test plan
All scenarios use `RESET_HOLD_CYCLES`=4, `TIMEOUT_CYCLES`=32, `SETTLE_CYCLES`=8, `MAX_RETRY`=2, macro off, unless stated otherwise.

1. Nominal bring-up:
   - Stimulus: `enable`=1, `gtpowergood`=7; `txok` 10 cycles after RESET exit; `locked` 5 cycles later.
   - Response: `gtwiz_reset_all` low after 4 RESET cycles; `out_en`=1 8 cycles after SETTLE entry; `retry_cnt`=0.
2. TX never completes:
   - Stimulus: `gtwiz_reset_tx_done` stuck at 0.
   - Response: three 32-cycle timeouts in WAIT_TX; `retry_cnt` goes 1, then 2; then FAULT with `fault`=1, `gtwiz_reset_all`=1, `out_en`=0.
   - Exit check: `enable`=0 then 1 clears FAULT and restarts from IDLE.
3. Lock drop in RUN:
   - Stimulus: `locked` low for 1 cycle.
   - Response: `out_en`=0 next cycle; `state`=RESET; `link_drop_cnt`=1; `out_en` re-asserts after the full sequence.
4. Exit/timeout same cycle:
   - Stimulus: `txok` rises exactly at timer value 31 in WAIT_TX.
   - Response: `state`=WAIT_LOCK; `retry_cnt` unchanged.
5. Enable drop and async reset:
   - Stimulus: `enable`=0 during WAIT_LOCK; separately, `resetn`=0 during RUN.
   - Response: for `enable`=0, IDLE next cycle and `retry_cnt`=0. For `resetn`=0, `out_en`=0 without waiting for an edge and all outputs take their reset values.
6. Synchronizer latency:
   - Stimulus: macro on; nominal scenario repeated.
   - Response: every status-driven transition occurs 2 cycles later than in scenario 1.

Source files
------------

// File: rtl/gth_tx_bringup_ctrl.sv
// gth_tx_bringup_ctrl: GTH TMDS TX bring-up supervisor FSM; define GTH_BRINGUP_SYNC_EN to add 2-flop status synchronizers
module gth_tx_bringup_ctrl #(
  parameter int RESET_HOLD_CYCLES = 64,
  parameter int TIMEOUT_CYCLES    = 65536,
  parameter int SETTLE_CYCLES     = 256,
  parameter int MAX_RETRY         = 3
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       enable,
  input  logic [2:0] gtpowergood,
  input  logic [2:0] txpmaresetdone,
  input  logic [2:0] txprgdivresetdone,
  input  logic       gtwiz_reset_tx_done,
  input  logic       locked,
  output logic       gtwiz_reset_all,
  output logic       out_en,
  output logic       fault,
  output logic [2:0] state,
  output logic [3:0] retry_cnt,
  output logic [7:0] link_drop_cnt
);
  localparam int MAX_A = RESET_HOLD_CYCLES > TIMEOUT_CYCLES ? RESET_HOLD_CYCLES : TIMEOUT_CYCLES;
  localparam int MAX_P = MAX_A > SETTLE_CYCLES ? MAX_A : SETTLE_CYCLES;
  localparam int TW = $clog2(MAX_P) + 1;
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] WAIT_PG   = 3'd1;
  localparam logic [2:0] RESET     = 3'd2;
  localparam logic [2:0] WAIT_TX   = 3'd3;
  localparam logic [2:0] WAIT_LOCK = 3'd4;
  localparam logic [2:0] SETTLE    = 3'd5;
  localparam logic [2:0] RUN       = 3'd6;
  localparam logic [2:0] FAULT     = 3'd7;
  logic [10:0] st_raw, st_s;
  logic pg, txok, lk, good;
  logic [TW-1:0] timer;
  logic [2:0] nxt, fail_st;
  logic tmo, hold_done, settle_done, give_up, spend, counting;
  assign st_raw = {gtpowergood, txpmaresetdone, txprgdivresetdone, gtwiz_reset_tx_done, locked};
`ifdef GTH_BRINGUP_SYNC_EN
  logic [10:0] st_m;
  // two-flop synchronizer on every status bit
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) {st_s, st_m} <= '0;
    else {st_s, st_m} <= {st_m, st_raw};
`else
  assign st_s = st_raw;
`endif
  assign pg          = &st_s[10:8];
  assign txok        = st_s[1] & (&st_s[7:5]) & (&st_s[4:2]);
  assign lk          = st_s[0];
  assign good        = pg & txok & lk;
  assign tmo         = timer == TW'(TIMEOUT_CYCLES - 1);
  assign hold_done   = timer == TW'(RESET_HOLD_CYCLES - 1);
  assign settle_done = timer == TW'(SETTLE_CYCLES - 1);
  assign give_up     = retry_cnt == 4'(MAX_RETRY);
  assign fail_st     = give_up ? FAULT : RESET;
  assign counting    = (state >= WAIT_PG) && (state <= SETTLE);
  assign spend       = enable & ((tmo & ((state == WAIT_PG & !pg) | (state == WAIT_TX & !txok) |
                       (state == WAIT_LOCK & txok & !lk))) | (state == SETTLE & !good));
  // next state: enable drop first, then exit condition, then timeout
  always_comb begin
    nxt = state;
    case (state)
      IDLE:      nxt = WAIT_PG;
      WAIT_PG:   nxt = pg ? RESET : tmo ? fail_st : WAIT_PG;
      RESET:     nxt = hold_done ? WAIT_TX : RESET;
      WAIT_TX:   nxt = txok ? WAIT_LOCK : tmo ? fail_st : WAIT_TX;
      WAIT_LOCK: nxt = !txok ? RESET : lk ? SETTLE : tmo ? fail_st : WAIT_LOCK;
      SETTLE:    nxt = !good ? fail_st : settle_done ? RUN : SETTLE;
      RUN:       nxt = good ? RUN : RESET;
      default:   nxt = FAULT;
    endcase
    if (!enable) nxt = IDLE;
  end
  // state register, per-state dwell timer, retry and link-drop counters
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state         <= IDLE;
      timer         <= '0;
      retry_cnt     <= '0;
      link_drop_cnt <= '0;
    end else begin
      state         <= nxt;
      timer         <= (nxt != state) ? '0 : timer + TW'(counting);
      retry_cnt     <= (nxt == IDLE || (nxt == RUN && state != RUN)) ? 4'd0 :
                       (spend && !give_up) ? retry_cnt + 4'd1 : retry_cnt;
      link_drop_cnt <= link_drop_cnt + 8'(state == RUN && nxt == RESET && link_drop_cnt != 8'hff);
    end
  assign gtwiz_reset_all = state == IDLE || state == WAIT_PG || state == RESET || state == FAULT;
  assign out_en          = state == RUN;
  assign fault           = state == FAULT;
endmodule

// File: tb/tb_gth_tx_bringup_ctrl.sv
// tb_gth_tx_bringup_ctrl: directed bring-up scenarios checked against a rule-level model every cycle
module tb_gth_tx_bringup_ctrl;
  localparam int R = 4, T = 32, S = 8, MR = 2;
`ifdef GTH_BRINGUP_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif
  localparam int IDLE = 0, WPG = 1, RST = 2, WTX = 3, WLK = 4, SET = 5, RUN = 6, FLT = 7;
  logic clk = 0, resetn = 0, enable = 0;
  logic [2:0] gtpowergood = 0, txpmaresetdone = 0, txprgdivresetdone = 0;
  logic gtwiz_reset_tx_done = 0, locked = 0;
  logic gtwiz_reset_all, out_en, fault;
  logic [2:0] state;
  logic [3:0] retry_cnt;
  logic [7:0] link_drop_cnt;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  gth_tx_bringup_ctrl #(.RESET_HOLD_CYCLES(R), .TIMEOUT_CYCLES(T), .SETTLE_CYCLES(S), .MAX_RETRY(MR)) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .gtpowergood(gtpowergood),
    .txpmaresetdone(txpmaresetdone), .txprgdivresetdone(txprgdivresetdone),
    .gtwiz_reset_tx_done(gtwiz_reset_tx_done), .locked(locked),
    .gtwiz_reset_all(gtwiz_reset_all), .out_en(out_en), .fault(fault),
    .state(state), .retry_cnt(retry_cnt), .link_drop_cnt(link_drop_cnt));

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Model: phase, cycles already spent in the phase, retries used, drops seen
  typedef struct packed { int st; int age; int retry; int drops; } mdl_t;
  mdl_t m = '0, m_nx;
  logic pg_raw, tx_raw, lk_raw, pg_v, tx_v, lk_v;
  assign pg_raw = &gtpowergood;
  assign tx_raw = gtwiz_reset_tx_done & (&txpmaresetdone) & (&txprgdivresetdone);
  assign lk_raw = locked;
`ifdef GTH_BRINGUP_SYNC_EN
  logic [2:0] p1, p2;
  always @(posedge clk or negedge resetn)
    if (!resetn) begin
      p1 <= 0;
      p2 <= 0;
    end else begin
      p1 <= {pg_raw, tx_raw, lk_raw};
      p2 <= p1;
    end
  assign {pg_v, tx_v, lk_v} = p2;
`else
  assign {pg_v, tx_v, lk_v} = {pg_raw, tx_raw, lk_raw};
`endif

  function automatic mdl_t model_next(mdl_t c, logic en, logic pg, logic tx, logic lk);
    mdl_t n = c;
    bit last_wait_cycle = (c.st == WPG || c.st == WTX || c.st == WLK) && c.age + 1 == T;
    bit spend = 0;
    case (c.st)
      IDLE: n.st = WPG;
      WPG:  if (pg) n.st = RST; else spend = last_wait_cycle;
      RST:  if (c.age + 1 == R) n.st = WTX;
      WTX:  if (tx) n.st = WLK; else spend = last_wait_cycle;
      WLK:  if (!tx) n.st = RST; else if (lk) n.st = SET; else spend = last_wait_cycle;
      SET:  if (!(pg && tx && lk)) spend = 1; else if (c.age + 1 == S) n.st = RUN;
      RUN:  if (!(pg && tx && lk)) begin
              n.st = RST;
              n.drops = (c.drops == 255) ? 255 : c.drops + 1;
            end
      default: ;
    endcase
    if (spend) begin
      if (c.retry == MR) n.st = FLT;
      else begin
        n.st = RST;
        n.retry = c.retry + 1;
      end
    end
    if (!en) begin
      n = c;
      n.st = IDLE;
    end
    if (n.st == IDLE || (n.st == RUN && c.st != RUN)) n.retry = 0;
    n.age = (n.st == c.st) ? c.age + 1 : 0;
    return n;
  endfunction

  always_comb m_nx = model_next(m, enable, pg_v, tx_v, lk_v);

  always @(posedge clk or negedge resetn)
    if (!resetn) m <= '0;
    else m <= m_nx;

  always @(negedge clk) begin
    chk("state", int'(state), m.st);
    chk("retry_cnt", int'(retry_cnt), m.retry);
    chk("link_drop_cnt", int'(link_drop_cnt), m.drops);
    chk("out_en", int'(out_en), int'(m.st == RUN));
    chk("fault", int'(fault), int'(m.st == FLT));
    chk("gtwiz_reset_all", int'(gtwiz_reset_all), int'(m.st == IDLE || m.st == WPG || m.st == RST || m.st == FLT));
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_st(input int s, input int budget, input string what);
    int k = 0;
    while (int'(state) != s && k < budget) begin
      tick();
      k++;
    end
    chk(what, int'(state), s);
  endtask

  task automatic dwell(input int s, output int n);
    n = 0;
    while (int'(state) == s && n < 200) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    tick(2);
    chk("rst_state", int'(state), IDLE);
    chk("rst_reset_all", int'(gtwiz_reset_all), 1);
    chk("rst_out_en", int'(out_en), 0);
    chk("rst_fault", int'(fault), 0);
    chk("rst_retry", int'(retry_cnt), 0);
    chk("rst_drops", int'(link_drop_cnt), 0);
    resetn = 1;
    // nominal bring-up
    gtpowergood = 3'h7;
    enable = 1;
    wait_st(RST, 20, "s1_enter_reset");
    dwell(RST, n);
    chk("s1_reset_cycles", n, R);
    chk("s1_after_reset", int'(state), WTX);
    chk("s1_reset_all_low", int'(gtwiz_reset_all), 0);
    tick(10);
    txpmaresetdone = 3'h7;
    txprgdivresetdone = 3'h7;
    gtwiz_reset_tx_done = 1;
    dwell(WTX, n);
    chk("s1_txok_latency", n, LAT);
    chk("s1_wait_lock", int'(state), WLK);
    tick(5);
    locked = 1;
    dwell(WLK, n);
    chk("s1_lock_latency", n, LAT);
    dwell(SET, n);
    chk("s1_settle_cycles", n, S);
    chk("s1_run", int'(state), RUN);
    chk("s1_out_en", int'(out_en), 1);
    chk("s1_retry", int'(retry_cnt), 0);
    // one-cycle lock drop in RUN
    locked = 0;
    tick(1);
    locked = 1;
    if (LAT > 1) tick(LAT - 1);
    chk("s3_state", int'(state), RST);
    chk("s3_out_en", int'(out_en), 0);
    chk("s3_drops", int'(link_drop_cnt), 1);
    wait_st(RUN, 200, "s3_rerun");
    chk("s3_out_en_back", int'(out_en), 1);
    // exit on the same cycle as the timeout
    gtwiz_reset_tx_done = 0;
    wait_st(WTX, 20, "s4_wait_tx");
    tick(T - LAT);
    gtwiz_reset_tx_done = 1;
    dwell(WTX, n);
    chk("s4_exit_cycle", n, LAT);
    chk("s4_state", int'(state), WLK);
    chk("s4_retry", int'(retry_cnt), 0);
    wait_st(RUN, 50, "s4_rerun");
    // one cycle later is a timeout, then enable drop in WAIT_LOCK
    gtwiz_reset_tx_done = 0;
    wait_st(WTX, 20, "s5_wait_tx");
    tick(T);
    chk("s5_timeout_state", int'(state), RST);
    chk("s5_timeout_retry", int'(retry_cnt), 1);
    chk("s5_drops", int'(link_drop_cnt), 3);
    locked = 0;
    gtwiz_reset_tx_done = 1;
    wait_st(WLK, 30, "s5_wait_lock");
    tick(3);
    chk("s5_retry_before", int'(retry_cnt), 1);
    enable = 0;
    tick(1);
    chk("s5_idle", int'(state), IDLE);
    chk("s5_idle_retry", int'(retry_cnt), 0);
    // TX never completes
    gtwiz_reset_tx_done = 0;
    enable = 1;
    wait_st(WTX, 30, "s2_wait_tx");
    dwell(WTX, n);
    chk("s2_timeout_cycles", n, T);
    chk("s2_retry1", int'(retry_cnt), 1);
    wait_st(WTX, 30, "s2_wait_tx2");
    dwell(WTX, n);
    chk("s2_retry2", int'(retry_cnt), 2);
    wait_st(FLT, 60, "s2_fault_state");
    tick(5);
    chk("s2_fault", int'(fault), 1);
    chk("s2_reset_all", int'(gtwiz_reset_all), 1);
    chk("s2_out_en", int'(out_en), 0);
    chk("s2_fault_retry", int'(retry_cnt), 2);
    enable = 0;
    tick(1);
    chk("s2_leave_fault", int'(state), IDLE);
    chk("s2_fault_clear", int'(fault), 0);
    enable = 1;
    tick(1);
    chk("s2_restart", int'(state), WPG);
    // asynchronous reset during RUN
    gtwiz_reset_tx_done = 1;
    locked = 1;
    wait_st(RUN, 200, "s5_run");
    #2;
    resetn = 0;
    #1;
    chk("s5_async_out_en", int'(out_en), 0);
    chk("s5_async_state", int'(state), IDLE);
    chk("s5_async_reset_all", int'(gtwiz_reset_all), 1);
    chk("s5_async_drops", int'(link_drop_cnt), 0);
    chk("s5_async_retry", int'(retry_cnt), 0);
    tick(2);
    resetn = 1;
    wait_st(RUN, 200, "s5_rerun");
    chk("s5_rerun_drops", int'(link_drop_cnt), 0);
    tick(3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
